// File: rtl/trap_filter_cfg.sv
// rtl/trap_filter_cfg.sv - run-time configurable trapezoidal shaper with FILL/RUN settle tracking
module trap_filter_cfg #(
    parameter int DATA_W = 12,
    parameter int ACC_W  = 48,
    parameter int K_MAX  = 64,
    parameter int L_MAX  = 64,
    parameter int K_DEF  = 8,
    parameter int L_DEF  = 4,
    parameter int M1     = 256,
    parameter int M2     = 1,
    parameter int SHIFT  = 8,
    localparam int KW    = $clog2(K_MAX + 1),
    localparam int LW    = $clog2(L_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_load,
    input  logic [KW-1:0]     cfg_k,
    input  logic [LW-1:0]     cfg_l,
    output logic              cfg_err,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] input_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] output_data,
    output logic              out_settled,
    output logic              out_sat
);
    localparam int KAW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int LAW = (L_MAX > 1) ? $clog2(L_MAX) : 1;
    localparam int CW  = $clog2(K_MAX + L_MAX + 4);
    localparam logic signed [ACC_W-1:0] M1_A  = ACC_W'(M1);
    localparam logic signed [ACC_W-1:0] M2_A  = ACC_W'(M2);
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic {ST_FILL, ST_RUN} state_t;
    state_t state_q, state_d;

    logic [KW-1:0]           k_q;
    logic [LW-1:0]           l_q;
    logic [CW-1:0]           cnt_q, cnt_d, thr;
    logic [DATA_W-1:0]       xl_q [K_MAX];
    logic signed [DATA_W:0]  dl_q [L_MAX];
    logic                    v1_q, v2_q, v3_q, v4_q, st1_q, st2_q, st3_q, st4_q;
    logic signed [ACC_W-1:0] pd_q, p_q, q_q, m1p_q, s_q;

    logic                    cfg_ok, run, tag, y_sat;
    logic [KW-1:0]           k_eff;
    logic [LW-1:0]           l_eff;
    logic [KAW-1:0]          k_idx;
    logic [LAW-1:0]          l_idx;
    logic signed [DATA_W:0]  x_new, x_last, x_old, d1_now, d1_old, dk;
    logic signed [ACC_W-1:0] k_s, dk_s, d1_s, pd, y;
    logic [DATA_W-1:0]       y_clamp;

    // An accepted config takes effect on the same edge, so the sample beside it sees zero history.
    always_comb begin
        cfg_ok = cfg_load && (cfg_k != '0) && (cfg_k <= KW'(K_MAX)) && (cfg_l <= LW'(L_MAX));
        k_eff  = cfg_ok ? cfg_k : k_q;
        l_eff  = cfg_ok ? cfg_l : l_q;
        k_idx  = KAW'(k_eff - KW'(1));
        l_idx  = LAW'(l_eff - LW'(1));
        x_new  = {1'b0, input_data};
        x_last = cfg_ok ? '0 : {1'b0, xl_q[0]};
        x_old  = cfg_ok ? '0 : {1'b0, xl_q[k_idx]};
        d1_now = x_new - x_last;
        d1_old = (l_eff == '0) ? d1_now : (cfg_ok ? '0 : dl_q[l_idx]);
        dk     = x_new - x_old;
        k_s    = ACC_W'(k_eff);
        dk_s   = ACC_W'(dk);
        d1_s   = ACC_W'(d1_old);
        pd     = dk_s - k_s * d1_s;
        thr    = (CW'(k_q) > CW'(l_q) + CW'(1)) ? CW'(k_q) : CW'(l_q) + CW'(1);
        tag    = !cfg_ok && (run || (cnt_q > thr));
    end

    always_comb begin
        y       = s_q >>> SHIFT;
        y_sat   = y[ACC_W-1] || (y > Y_MAX);
        y_clamp = y[ACC_W-1] ? '0 : ((y > Y_MAX) ? '1 : y[DATA_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (cfg_ok) state_d = ST_FILL; else if (cnt_q > thr) state_d = ST_RUN;
            ST_RUN:  if (cfg_ok) state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    always_comb begin
        run = (state_q == ST_RUN);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cfg_ok)                cnt_d = in_valid ? CW'(1) : '0;
        else if (in_valid && !run) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q   <= KW'(K_DEF);
            l_q   <= LW'(L_DEF);
            cnt_q <= '0;
            for (int i = 0; i < K_MAX; i++) xl_q[i] <= '0;
            for (int i = 0; i < L_MAX; i++) dl_q[i] <= '0;
            {v1_q, v2_q, v3_q, v4_q, st1_q, st2_q, st3_q, st4_q} <= '0;
            pd_q        <= '0;
            p_q         <= '0;
            q_q         <= '0;
            m1p_q       <= '0;
            s_q         <= '0;
            cfg_err     <= 1'b0;
            out_valid   <= 1'b0;
            output_data <= '0;
            out_settled <= 1'b0;
            out_sat     <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_ok) begin
                k_q <= cfg_k;
                l_q <= cfg_l;
                for (int i = 0; i < K_MAX; i++) xl_q[i] <= '0;
                for (int i = 0; i < L_MAX; i++) dl_q[i] <= '0;
            end
            if (in_valid) begin
                xl_q[0] <= input_data;
                dl_q[0] <= d1_now;
                for (int i = 1; i < K_MAX; i++) xl_q[i] <= cfg_ok ? '0 : xl_q[i-1];
                for (int i = 1; i < L_MAX; i++) dl_q[i] <= cfg_ok ? '0 : dl_q[i-1];
                pd_q <= pd;
            end
            // Samples already past stage 0 are dropped on a config change; the one leaving s now still emits.
            v1_q  <= in_valid;
            v2_q  <= v1_q && !cfg_ok;
            v3_q  <= v2_q && !cfg_ok;
            v4_q  <= v3_q && !cfg_ok;
            st1_q <= tag;
            st2_q <= st1_q;
            st3_q <= st2_q;
            st4_q <= st3_q;
            if (cfg_ok)    p_q <= '0;
            else if (v1_q) p_q <= p_q + pd_q;
            if (cfg_ok)    q_q <= '0;
            else if (v2_q) q_q <= q_q + M2_A * p_q;
            if (v2_q)      m1p_q <= M1_A * p_q;
            if (cfg_ok)    s_q <= '0;
            else if (v3_q) s_q <= s_q + q_q + m1p_q;
            out_valid <= v4_q;
            if (v4_q) begin
                output_data <= y_clamp;
                out_settled <= st4_q;
                out_sat     <= y_sat;
            end
        end
    end
endmodule
